// File: rtl/mx_dot_pkg.sv
// Shared constants, FSM state type and width helpers for the MX dot-product job sequencer.
package mx_dot_pkg;

  localparam int unsigned E8M0_BIAS = 127;
  localparam logic [7:0]  E8M0_NAN  = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } sched_state_t;

  function automatic int unsigned prd_width_f(input int unsigned exp_w, input int unsigned man_w);
    return 2 * ((1 << exp_w) + man_w);
  endfunction

  function automatic int unsigned dp_width_f(input int unsigned exp_w, input int unsigned man_w,
                                             input int unsigned kk);
    return prd_width_f(exp_w, man_w) + $clog2(kk);
  endfunction

  function automatic int unsigned acc_width_f(input int unsigned exp_w, input int unsigned man_w,
                                              input int unsigned kk, input int unsigned mb);
    return dp_width_f(exp_w, man_w, kk) + $clog2(mb);
  endfunction

  // Combined power-of-two exponent of two E8M0 scales, 10-bit signed.
  function automatic logic signed [9:0] e8m0_sum_exp(input logic [7:0] sa, input logic [7:0] sb);
    return $signed(10'(sa) + 10'(sb) - 10'(2 * E8M0_BIAS));
  endfunction

endpackage

// File: rtl/dot_fp6.sv
// Combinational k-element signed minifloat dot product in fixed point
// (LSB of each element = smallest subnormal, so 1.0*1.0 = 2^(2*(bias+man_width-1))).
module dot_fp6 import mx_dot_pkg::*; #(
  parameter int unsigned exp_width = 5,
  parameter int unsigned man_width = 2,
  parameter int unsigned k         = 32,
  localparam int unsigned bit_width = 1 + exp_width + man_width,
  localparam int unsigned prd_width = prd_width_f(exp_width, man_width),
  localparam int unsigned dp_width  = dp_width_f(exp_width, man_width, k)
) (
  input  logic [k-1:0][bit_width-1:0] a,
  input  logic [k-1:0][bit_width-1:0] b,
  output logic signed [dp_width-1:0]  dp
);

  // Subnormals share the scale of exponent 1, hence no shift for e==0.
  function automatic logic [exp_width-1:0] elem_shift(input logic [exp_width-1:0] e);
    return (e == '0) ? '0 : e - exp_width'(1);
  endfunction

  function automatic logic signed [prd_width-1:0] mul_elem(input logic [bit_width-1:0] x,
                                                           input logic [bit_width-1:0] y);
    logic [exp_width-1:0] ex;
    logic [exp_width-1:0] ey;
    logic [exp_width:0]   sh;
    logic [prd_width-1:0] mag;
    ex  = x[bit_width-2 -: exp_width];
    ey  = y[bit_width-2 -: exp_width];
    sh  = {1'b0, elem_shift(ex)} + {1'b0, elem_shift(ey)};
    mag = prd_width'({ex != '0, x[man_width-1:0]}) * prd_width'({ey != '0, y[man_width-1:0]});
    mag = mag << sh;
    return (x[bit_width-1] ^ y[bit_width-1]) ? -$signed(mag) : $signed(mag);
  endfunction

  always_comb begin
    dp = '0;
    for (int unsigned j = 0; j < k; j++) begin
      dp = dp + dp_width'(mul_elem(a[j], b[j]));
    end
  end

endmodule

// File: rtl/mx_dot_sched.sv
// Job sequencer: streams nblk operand blocks through dot_fp6 into a two-stage
// (P1 register, P2 accumulate) pipeline and returns the scaled sum over valid/ready.
module mx_dot_sched import mx_dot_pkg::*; #(
  parameter int unsigned exp_width = 5,
  parameter int unsigned man_width = 2,
  parameter int unsigned k         = 32,
  parameter int unsigned max_blk   = 256,
  localparam int unsigned bit_width = 1 + exp_width + man_width,
  localparam int unsigned dp_width  = dp_width_f(exp_width, man_width, k),
  localparam int unsigned acc_width = acc_width_f(exp_width, man_width, k, max_blk),
  localparam int unsigned cnt_width = $clog2(max_blk + 1)
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_job_valid,
  output logic                         o_job_ready,
  input  logic [cnt_width-1:0]         i_job_nblk,
  input  logic [7:0]                   i_job_scale_a,
  input  logic [7:0]                   i_job_scale_b,
  input  logic                         i_blk_valid,
  output logic                         o_blk_ready,
  input  logic [k-1:0][bit_width-1:0]  i_blk_a,
  input  logic [k-1:0][bit_width-1:0]  i_blk_b,
  output logic                         o_res_valid,
  input  logic                         i_res_ready,
  output logic signed [acc_width-1:0]  o_res_acc,
  output logic signed [9:0]            o_res_exp,
  output logic                         o_res_nan,
  output logic                         o_busy
);

  sched_state_t                 state;
  logic [cnt_width-1:0]         nblk;
  logic [cnt_width-1:0]         issued;
  logic [cnt_width-1:0]         done;
  logic                         p1_valid;
  logic signed [dp_width-1:0]   p1_dp;
  logic signed [dp_width-1:0]   dp;
  logic signed [acc_width-1:0]  acc;
  logic                         blk_hs;
  logic                         job_hs;

  dot_fp6 #(
    .exp_width (exp_width),
    .man_width (man_width),
    .k         (k)
  ) u_dot (
    .a  (i_blk_a),
    .b  (i_blk_b),
    .dp (dp)
  );

  assign o_blk_ready = (state == RUN) && (issued != nblk);
  assign o_busy      = (state != IDLE);
  assign o_res_acc   = acc;
  assign blk_hs      = i_blk_valid && o_blk_ready;
  assign job_hs      = i_job_valid && o_job_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      nblk        <= '0;
      issued      <= '0;
      done        <= '0;
      p1_valid    <= 1'b0;
      p1_dp       <= '0;
      acc         <= '0;
      o_job_ready <= 1'b0;
      o_res_valid <= 1'b0;
      o_res_exp   <= '0;
      o_res_nan   <= 1'b0;
    end else begin
      p1_valid <= blk_hs;
      if (blk_hs) begin
        p1_dp  <= dp;
        issued <= issued + cnt_width'(1);
      end
      unique case (state)
        IDLE: begin
          o_job_ready <= 1'b1;
          if (job_hs) begin
            nblk        <= i_job_nblk;
            issued      <= '0;
            done        <= '0;
            acc         <= '0;
            o_res_exp   <= e8m0_sum_exp(i_job_scale_a, i_job_scale_b);
            o_res_nan   <= (i_job_scale_a == E8M0_NAN) || (i_job_scale_b == E8M0_NAN);
            o_job_ready <= 1'b0;
            if (i_job_nblk == '0) begin
              state       <= DONE;
              o_res_valid <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (p1_valid) begin
            acc  <= acc + acc_width'(p1_dp);
            done <= done + cnt_width'(1);
            if (done + cnt_width'(1) == nblk) begin
              state       <= DONE;
              o_res_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (i_res_ready) begin
            state       <= IDLE;
            o_res_valid <= 1'b0;
            o_job_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mx_dot_sched.sv
// Directed bench for mx_dot_sched: table of jobs with hand-computed sums plus a mid-job reset sequence.
module tb_mx_dot_sched;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      job_valid;
  logic                      job_ready;
  logic [8:0]                job_nblk;
  logic [7:0]                job_scale_a;
  logic [7:0]                job_scale_b;
  logic                      blk_valid;
  logic                      blk_ready;
  logic [31:0][7:0]          blk_a;
  logic [31:0][7:0]          blk_b;
  logic                      res_valid;
  logic                      res_ready;
  logic signed [80:0]        res_acc;
  logic signed [9:0]         res_exp;
  logic                      res_nan;
  logic                      busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mx_dot_sched #(
    .exp_width (5),
    .man_width (2),
    .k         (32),
    .max_blk   (256)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_job_valid   (job_valid),
    .o_job_ready   (job_ready),
    .i_job_nblk    (job_nblk),
    .i_job_scale_a (job_scale_a),
    .i_job_scale_b (job_scale_b),
    .i_blk_valid   (blk_valid),
    .o_blk_ready   (blk_ready),
    .i_blk_a       (blk_a),
    .i_blk_b       (blk_b),
    .o_res_valid   (res_valid),
    .i_res_ready   (res_ready),
    .o_res_acc     (res_acc),
    .o_res_exp     (res_exp),
    .o_res_nan     (res_nan),
    .o_busy        (busy)
  );

  always @(posedge clk) begin
    if (job_valid && job_ready)
      assert (job_nblk <= 9'd256) else $error("illegal job nblk %0d", job_nblk);
  end

  // Sums are in dot_fp6 fixed units: 1.0*1.0 = 2^32, so one block of +1.0 pairs = 32<<32.
  // Block j of a job uses a[8j+:8] / b[8j+:8] for all 32 elements.
  typedef struct {
    logic [8:0]         nblk;
    logic [7:0]         sa;
    logic [7:0]         sb;
    logic [31:0]        a;
    logic [31:0]        b;
    bit                 bubble;
    int                 hold;
    logic signed [80:0] acc;
    logic signed [9:0]  exp;
    bit                 nan;
  } vec_t;

  vec_t vecs[7];
  vec_t post_rst;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic fill(input logic [7:0] a, input logic [7:0] b);
    for (int j = 0; j < 32; j++) begin
      blk_a[j] = a;
      blk_b[j] = b;
    end
  endtask

  task automatic wait_job_ready();
    int w = 0;
    while (!job_ready && w < 20) begin
      step();
      w++;
    end
    check("job_ready_wait", job_ready, 1'b1);
  endtask

  task automatic do_job(input vec_t v);
    int cyc, nsent, nacc, last, extra;
    logic [80:0] r_acc;
    logic [9:0]  r_exp;
    logic        r_nan;
    bit          stable;
    wait_job_ready();
    job_nblk    = v.nblk;
    job_scale_a = v.sa;
    job_scale_b = v.sb;
    job_valid   = 1'b1;
    step();
    job_valid = 1'b0;
    cyc = 0; nsent = 0; nacc = 0; last = -10; extra = 0;
    while (!res_valid && cyc < 200) begin
      if (nsent < int'(v.nblk)) begin
        blk_valid = v.bubble ? 1'($urandom_range(0, 1)) : 1'b1;
        fill(v.a[8*nsent +: 8], v.b[8*nsent +: 8]);
      end else begin
        blk_valid = !v.bubble;
        fill(8'h3C, 8'h3C);
        if (blk_ready) extra++;
      end
      if (blk_valid && blk_ready) begin
        nacc++;
        last = cyc;
        if (nsent < int'(v.nblk)) nsent++;
      end
      step();
      cyc++;
    end
    check("res_valid", res_valid, 1'b1);
    check("latency", cyc, (v.nblk == 0) ? 0 : last + 2);
    check("accepts", nacc, v.nblk);
    check("ready_after_last", extra, 0);
    if (!v.bubble && v.nblk > 1)
      check("back_to_back", last, v.nblk - 1);
    r_acc  = res_acc;
    r_exp  = res_exp;
    r_nan  = res_nan;
    stable = 1'b1;
    for (int h = 0; h < v.hold; h++) begin
      step();
      if (res_acc !== r_acc || res_exp !== r_exp || res_nan !== r_nan || !res_valid ||
          job_ready || (blk_valid && blk_ready))
        stable = 1'b0;
    end
    if (v.hold > 0) check("hold_stable", stable, 1'b1);
    check("res_acc", res_acc, v.acc);
    check("res_exp", res_exp, v.exp);
    check("res_nan", res_nan, v.nan);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    blk_valid = 1'b0;
    check("post_handshake", {res_valid, job_ready, busy}, 3'b010);
  endtask

  initial begin
    rst_n = 1'b0; job_valid = 1'b0; job_nblk = '0; job_scale_a = '0; job_scale_b = '0;
    blk_valid = 1'b0; res_ready = 1'b0;
    fill(8'h00, 8'h00);

    //          nblk  sa      sb      a             b             bub  hold acc                                          exp        nan
    vecs[0] = '{9'd1, 8'd127, 8'd127, 32'h0000003C, 32'h0000003C, 1'b0, 0, 81'sd32 <<< 32,                             10'sd0,    1'b0};
    vecs[1] = '{9'd4, 8'd128, 8'd127, 32'h3EBC403C, 32'h3E403C3C, 1'b0, 0, 81'sd104 <<< 32,                            10'sd1,    1'b0};
    vecs[2] = '{9'd0, 8'd130, 8'd120, 32'h0,        32'h0,        1'b0, 0, 81'sd0,                                     -10'sd4,   1'b0};
    vecs[3] = '{9'd3, 8'd200, 8'd54,  32'h007F0138, 32'h007F0140, 1'b1, 5, (81'sd49 <<< 65) + (81'sd32 <<< 32) + 81'sd32, 10'sd0, 1'b0};
    vecs[4] = '{9'd1, 8'd255, 8'd127, 32'h000000BC, 32'h0000003C, 1'b0, 2, -(81'sd32 <<< 32),                          10'sd128,  1'b1};
    vecs[5] = '{9'd2, 8'd255, 8'd255, 32'h00003800, 32'h0000387F, 1'b0, 0, 81'sd8 <<< 32,                              10'sd256,  1'b1};
    vecs[6] = '{9'd1, 8'd0,   8'd0,   32'h00000081, 32'h00000001, 1'b1, 0, -81'sd32,                                   -10'sd254, 1'b0};
    post_rst = '{9'd1, 8'd127, 8'd127, 32'h00000040, 32'h00000040, 1'b0, 0, 81'sd128 <<< 32,                           10'sd0,    1'b0};

    repeat (3) step();
    check("reset_outputs", {job_ready, blk_ready, res_valid, busy, res_nan, res_exp, res_acc}, '0);
    rst_n = 1'b1;
    check("job_ready_in_first_cycle", job_ready, 1'b0);
    step();
    check("job_ready_rises", job_ready, 1'b1);

    for (int i = 0; i < 7; i++) do_job(vecs[i]);

    // Abort a 4-block job after two accepted blocks.
    wait_job_ready();
    job_nblk = 9'd4; job_scale_a = 8'd127; job_scale_b = 8'd127; job_valid = 1'b1;
    step();
    job_valid = 1'b0;
    fill(8'h3C, 8'h3C);
    blk_valid = 1'b1;
    step();
    step();
    blk_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_job_reset", {job_ready, blk_ready, res_valid, busy, res_nan, res_exp, res_acc}, '0);
    step();
    rst_n = 1'b1;
    check("job_ready_after_abort0", job_ready, 1'b0);
    step();
    check("job_ready_after_abort1", job_ready, 1'b1);
    do_job(post_rst);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
